wb_fifo_port: RTL

- Wishbone classic slave that sits directly downstream of limb_interface, alongside or in place of wb_ram.
- Exposes a pair of FIFOs to the LIMB host.
  - Host writes to DATA push into a TX FIFO, which drains to a valid/ready stream port.
  - Stream words arriving on the RX port fill an RX FIFO, which host reads of DATA pop.
- STATUS and CONTROL registers give levels, flags and flush.

---
 rtl/wb_fifo_port_if.sv | 34 +++
 rtl/wb_fifo_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fifo_port_if.sv
// Wishbone classic bus bundle for wb_fifo_port.
// The master drives the request side, the slave returns data and ack.
interface wb_fifo_port_if;
    logic [3:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;

    modport master (
        output adr_i,
        output dat_i,
        output we_i,
        output sel_i,
        output stb_i,
        output cyc_i,
        input  dat_o,
        input  ack_o
    );

    modport slave (
        input  adr_i,
        input  dat_i,
        input  we_i,
        input  sel_i,
        input  stb_i,
        input  cyc_i,
        output dat_o,
        output ack_o
    );
endinterface

// File: rtl/wb_fifo_port.sv
// Wishbone slave exposing a TX/RX FIFO pair to a valid/ready stream.
// Define WB_FIFO_PORT_IRQ_EN to add the irq output and IRQ_MASK register.
module wb_fifo_port #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    wb_fifo_port_if.slave wb,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef WB_FIFO_PORT_IRQ_EN
   ,output logic        irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         lvl_t;

    localparam lvl_t LVL_FULL = lvl_t'(DEPTH);
    localparam lvl_t LVL_HALF = lvl_t'(DEPTH / 2);

    logic [31:0] tx_mem [DEPTH];
    logic [31:0] rx_mem [DEPTH];

    ptr_t tx_wr;
    ptr_t tx_rd;
    ptr_t rx_wr;
    ptr_t rx_rd;
    lvl_t tx_lvl;
    lvl_t rx_lvl;

    logic tx_ovf;
    logic rx_unf;

    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;

    logic access;
    logic is_data;
    logic is_stat;
    logic is_ctrl;
    logic is_rsvd;

    logic [31:0] lane_mask;
    logic [31:0] wr_word;
    logic [31:0] status;
    logic [31:0] rd_word;

    logic data_wr;
    logic data_rd;
    logic ctrl_wr;

    logic tx_push;
    logic tx_pop;
    logic tx_flush;
    logic tx_ovf_set;
    logic rx_push;
    logic rx_pop;
    logic rx_flush;
    logic rx_unf_set;
    logic flag_clr;

    logic unused_adr;

    assign unused_adr = ^wb.adr_i[1:0];

    // An access fires once per request; the ack cycle blocks re-entry.
    assign access  = wb.cyc_i & wb.stb_i & ~wb.ack_o;

    assign is_data = (wb.adr_i[3:2] == 2'd0);
    assign is_stat = (wb.adr_i[3:2] == 2'd1);
    assign is_ctrl = (wb.adr_i[3:2] == 2'd2);
    assign is_rsvd = (wb.adr_i[3:2] == 2'd3);

    assign tx_full  = (tx_lvl == LVL_FULL);
    assign tx_empty = (tx_lvl == '0);
    assign rx_full  = (rx_lvl == LVL_FULL);
    assign rx_empty = (rx_lvl == '0);

    assign lane_mask = {
        {8{wb.sel_i[3]}},
        {8{wb.sel_i[2]}},
        {8{wb.sel_i[1]}},
        {8{wb.sel_i[0]}}
    };
    assign wr_word = wb.dat_i & lane_mask;

    assign data_wr = access & wb.we_i & is_data & (|wb.sel_i);
    assign data_rd = access & ~wb.we_i & is_data;
    assign ctrl_wr = access & wb.we_i & is_ctrl & wb.sel_i[0];

    // Fullness/emptiness is judged on pre-edge state only.
    assign tx_push    = data_wr & ~tx_full;
    assign tx_ovf_set = data_wr & tx_full;
    assign tx_pop     = ~tx_empty & tx_ready;
    assign tx_flush   = ctrl_wr & wb.dat_i[0];

    assign rx_push    = rx_valid & ~rx_full;
    assign rx_pop     = data_rd & ~rx_empty;
    assign rx_unf_set = data_rd & rx_empty;
    assign rx_flush   = ctrl_wr & wb.dat_i[1];

    assign flag_clr   = ctrl_wr & wb.dat_i[2];

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rd];
    assign rx_ready = ~rx_full;

    assign status = {
        12'd0,
        rx_unf,
        tx_ovf,
        rx_empty,
        tx_full,
        8'(rx_lvl),
        8'(tx_lvl)
    };

`ifdef WB_FIFO_PORT_IRQ_EN
    logic [3:0] irq_mask;
    logic [3:0] irq_src;
    logic       mask_wr;

    assign mask_wr = access & wb.we_i & is_rsvd & wb.sel_i[0];

    assign irq_src = {
        rx_unf,
        tx_ovf,
        ~rx_empty,
        (tx_lvl <= LVL_HALF)
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (mask_wr) begin
                irq_mask <= wb.dat_i[3:0];
            end
            irq <= |(irq_mask & irq_src);
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        if (!wb.we_i) begin
            unique case (1'b1)
                is_data: rd_word = rx_empty ? '0 : rx_mem[rx_rd];
                is_stat: rd_word = status;
                is_ctrl: rd_word = '0;
`ifdef WB_FIFO_PORT_IRQ_EN
                is_rsvd: rd_word = {28'd0, irq_mask};
`else
                is_rsvd: rd_word = '0;
`endif
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb.ack_o <= 1'b0;
            wb.dat_o <= '0;
        end else begin
            wb.ack_o <= access;
            wb.dat_o <= access ? rd_word : '0;
        end
    end

    // Storage carries no reset; pointers and levels define validity.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr] <= wr_word;
        end
        if (rx_push) begin
            rx_mem[rx_wr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tx_flush) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_lvl <= '0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + ptr_t'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + ptr_t'(1);
            end
            tx_lvl <= tx_lvl + lvl_t'(tx_push) - lvl_t'(tx_pop);
        end
    end

    // A stream handshake in the flush cycle is discarded with the rest.
    always_ff @(posedge clk) begin
        if (reset || rx_flush) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_lvl <= '0;
        end else begin
            if (rx_push) begin
                rx_wr <= rx_wr + ptr_t'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + ptr_t'(1);
            end
            rx_lvl <= rx_lvl + lvl_t'(rx_push) - lvl_t'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flag_clr) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (tx_ovf_set) begin
                tx_ovf <= 1'b1;
            end
            if (rx_unf_set) begin
                rx_unf <= 1'b1;
            end
        end
    end

endmodule
